ysyx_25040111_axi_slave_mem: RTL and testbench
==============================================

// Module: ysyx_25040111_axi_slave_mem
// PURPOSE
//   AXI4 responder (slave) with on-chip word-addressed memory. It is the far end of the
//   core's master port: it accepts AR/AW/W bursts and returns R/B responses.
//   Used as bench memory and as an SoC-less target for the LSU/icache burst path.
//   One outstanding transaction at a time. Reads have priority over writes.
// PARAMETERS
//   MEM_AW    10  log2 of memory depth in 32-bit words (1024 words = 4 KiB)
//   BASE      32'h8000_0000  byte address of word 0
//   RD_DELAY  0   extra wait cycles between AR handshake and the first R beat
// PORTS
//   clock       in   1   single clock; all logic on posedge
//   reset       in   1   synchronous, active-low (0 = reset)
//   awready     out  1   AW accept
//   awvalid     in   1   AW request valid
//   awaddr      in   32  write start byte address
//   awid        in   4   write id
//   awlen       in   8   beats-1
//   awsize      in   3   bytes/beat = 1<<awsize (<=2)
//   awburst     in   2   00 FIXED, 01 INCR, 10 WRAP
//   wready      out  1   W accept
//   wvalid      in   1   W beat valid
//   wdata       in   32  write data
//   wstrb       in   4   byte-lane enables
//   wlast       in   1   master's last-beat flag
//   bready      in   1   B accept
//   bvalid      out 1   write response valid
//   bresp       out  2   00 OKAY, 10 SLVERR, 11 DECERR
//   bid         out  4   = latched awid
//   arready     out  1   AR accept
//   arvalid, araddr[32], arid[4], arlen[8], arsize[3], arburst[2]   in   AR channel, same meaning as AW
//   rready      in   1   R accept
//   rvalid      out  1   read beat valid
//   rresp       out  2   per-beat response, encoding as bresp
//   rdata       out  32  read data
//   rlast       out  1   final beat of the burst
//   rid         out  4   = latched arid
// BEHAVIOUR
//   FSM: IDLE, RD_WAIT, RD_DATA, WR_DATA, WR_RESP. Reset (reset==0 at posedge) -> IDLE.
//   While in reset, all outputs are 0. Memory contents are not reset.
//   IDLE: arready=1. awready=~arvalid. A simultaneous arvalid and awvalid accepts the read only.
//   AR handshake latches addr/len/size/burst/id and clears the beat counter. Next state is
//   RD_WAIT when RD_DELAY>0, else RD_DATA.
//   RD_WAIT counts RD_DELAY cycles, then goes to RD_DATA.
//   RD_DATA: rvalid=1 and rdata=mem[addr[MEM_AW+1:2]-BASE/4], registered.
//   rdata/rresp/rlast hold stable while rvalid&~rready.
//   - On each rvalid&rready: advance the address and increment the counter. The beat with
//     counter==len has rlast=1 and returns to IDLE in the next cycle. Latency for
//     RD_DELAY=0 is AR handshake to rvalid = 1 cycle.
//   AW handshake latches the same fields plus id, then goes to WR_DATA.
//   WR_DATA: wready=1. Each wvalid&wready writes the enabled byte lanes and advances the
//   address. After beat len, go to WR_RESP.
//   - A wlast value that disagrees with (counter==len) on any beat sets a sticky SLVERR.
//     The burst still ends after exactly len+1 beats.
//   WR_RESP: bvalid=1 until bready, then IDLE. The first AW accept after B can occur the
//   cycle after the B handshake.
//   Address advance: INCR adds 1<<size. FIXED keeps the address. WRAP is unsupported:
//   every beat gets SLVERR, reads return 0, writes are dropped, and beat count is honoured.
//   Decode: an address outside [BASE, BASE+4<<MEM_AW) gives DECERR for that beat.
//   Reads return 0 and writes are dropped. The check applies per beat, so a burst can
//   cross the boundary. Error priority: DECERR > SLVERR > OKAY. bresp reports the worst beat.
//   - Sub-word reads return the full aligned word. Byte selection is the master's job.
//   - awlen/arlen=255 gives 256 beats. The counter is 8 bits and compared with ==len, so
//     there is no wrap.
//   - Reset mid-burst: the transaction is abandoned. There is no further R or B.
//     Completed writes remain.
// TESTING
//   1 Reset: hold reset=0 for 2 cycles -> all outputs 0. Release -> arready=1, awready=1.
//   2 Single write: AW addr 0x8000_0010 len0 INCR, W 0xDEADBEEF strb 0xF wlast=1
//     -> bvalid, bresp=00, bid=awid. Then AR same addr -> rdata 0xDEADBEEF, rlast=1.
//   3 INCR read burst: arlen=7 from 0x8000_0000, rready toggling 1/0
//     -> 8 beats in order, data held during stalls, rlast only on beat 8.
//   4 Arbitration: arvalid and awvalid in the same cycle -> AR accepted, awready=0.
//     AW is accepted only after the read's last beat.
//   5 Errors: AR to 0x7FFF_FFFC -> rresp=11, rdata=0. awburst=10 len1 -> bresp=10.
//     Early wlast on beat 0 of a len3 burst -> 4 beats accepted, bresp=10.
//   6 Strobe and mid-reset: write 0x11223344 strb 0x5 over 0xFFFFFFFF -> read 0xFF22FF44.
//     Reset asserted during beat 3 of an 8-beat read -> rvalid=0, FSM in IDLE.

Source files
------------

// File: rtl/ysyx_25040111_axi_slave_mem_if.sv
// AXI4 bus between a master and the on-chip memory responder.
interface ysyx_25040111_axi_slave_mem_if;
    logic        awready;
    logic        awvalid;
    logic [31:0] awaddr;
    logic [3:0]  awid;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        wready;
    logic        wvalid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        bready;
    logic        bvalid;
    logic [1:0]  bresp;
    logic [3:0]  bid;
    logic        arready;
    logic        arvalid;
    logic [31:0] araddr;
    logic [3:0]  arid;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        rready;
    logic        rvalid;
    logic [1:0]  rresp;
    logic [31:0] rdata;
    logic        rlast;
    logic [3:0]  rid;

    modport slave (
        output awready, wready, bvalid, bresp, bid, arready, rvalid, rresp, rdata, rlast, rid,
        input  awvalid, awaddr, awid, awlen, awsize, awburst, wvalid, wdata, wstrb, wlast,
        input  bready, arvalid, araddr, arid, arlen, arsize, arburst, rready
    );

    modport master (
        input  awready, wready, bvalid, bresp, bid, arready, rvalid, rresp, rdata, rlast, rid,
        output awvalid, awaddr, awid, awlen, awsize, awburst, wvalid, wdata, wstrb, wlast,
        output bready, arvalid, araddr, arid, arlen, arsize, arburst, rready
    );
endinterface

// File: rtl/ysyx_25040111_axi_slave_mem.sv
// AXI4 responder backed by a word-addressed on-chip memory. One transaction in
// flight at a time; a read request wins over a simultaneous write request.
module ysyx_25040111_axi_slave_mem #(
    parameter int          MEM_AW   = 10,
    parameter logic [31:0] BASE     = 32'h8000_0000,
    parameter int          RD_DELAY = 0
) (
    input logic                          clock,
    input logic                          reset,
    ysyx_25040111_axi_slave_mem_if.slave bus
);
    // state   | meaning
    // IDLE    | waiting for AR (preferred) or AW
    // RD_WAIT | counting RD_DELAY cycles before the first R beat
    // RD_DATA | presenting read beats
    // WR_DATA | accepting write beats
    // WR_RESP | presenting the B response
    typedef enum logic [2:0] {IDLE, RD_WAIT, RD_DATA, WR_DATA, WR_RESP} state_t;

    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [1:0]  RESP_DECERR = 2'b11;
    localparam logic [32:0] MEM_BYTES   = 33'd4 << MEM_AW;
    localparam int          DW          = (RD_DELAY > 1) ? $clog2(RD_DELAY + 1) : 1;

    state_t            state_q, state_d;
    logic [31:0]       mem [0:(1 << MEM_AW) - 1];
    logic [31:0]       addr_q, rdata_q;
    logic [7:0]        len_q, cnt_q;
    logic [2:0]        size_q;
    logic [1:0]        burst_q, rresp_q, bresp_q;
    logic [3:0]        id_q;
    logic [DW-1:0]     wait_q;

    logic [31:0]       look_addr, addr_nxt, look_data, rd_off, wr_off;
    logic [1:0]        look_burst, look_resp, wr_resp;
    logic [MEM_AW-1:0] rd_idx, wr_idx;
    logic              rd_load, cnt_last, wr_ok;
    logic              arready_c, awready_c, wready_c, rvalid_c, bvalid_c;
    logic              ar_hs, aw_hs, r_hs, w_hs;
    logic              unused_off;

    // Decode error outranks the unsupported-burst error.
    function automatic logic [1:0] beat_resp(input logic [31:0] addr, input logic [1:0] burst);
        logic [31:0] off;
        off = addr - BASE;
        if ({1'b0, off} >= MEM_BYTES) return RESP_DECERR;
        if (burst != 2'b00 && burst != 2'b01) return RESP_SLVERR;
        return RESP_OKAY;
    endfunction

    assign cnt_last   = (cnt_q == len_q);
    assign addr_nxt   = (burst_q == 2'b01) ? addr_q + (32'd1 << size_q) : addr_q;
    assign ar_hs      = bus.arvalid & bus.arready;
    assign aw_hs      = bus.awvalid & bus.awready;
    assign r_hs       = bus.rvalid & bus.rready;
    assign w_hs       = bus.wvalid & bus.wready;

    assign rd_off     = look_addr - BASE;
    assign rd_idx     = rd_off[MEM_AW+1:2];
    assign look_resp  = beat_resp(look_addr, look_burst);
    assign look_data  = (look_resp == RESP_OKAY) ? mem[rd_idx] : 32'd0;
    assign wr_off     = addr_q - BASE;
    assign wr_idx     = wr_off[MEM_AW+1:2];
    assign wr_ok      = (beat_resp(addr_q, burst_q) == RESP_OKAY);
    assign unused_off = ^{rd_off[1:0], rd_off[31:MEM_AW+2], wr_off[1:0], wr_off[31:MEM_AW+2]};

    always_comb begin
        wr_resp = beat_resp(addr_q, burst_q);
        if ((bus.wlast != cnt_last) && (wr_resp == RESP_OKAY)) wr_resp = RESP_SLVERR;
    end

    always_ff @(posedge clock) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        arready_c  = 1'b0;
        awready_c  = 1'b0;
        wready_c   = 1'b0;
        rvalid_c   = 1'b0;
        bvalid_c   = 1'b0;
        rd_load    = 1'b0;
        look_addr  = addr_q;
        look_burst = burst_q;
        case (state_q)
            IDLE: begin
                arready_c = 1'b1;
                awready_c = ~bus.arvalid;
                if (bus.arvalid) begin
                    look_addr  = bus.araddr;
                    look_burst = bus.arburst;
                    if (RD_DELAY == 0) begin
                        state_d = RD_DATA;
                        rd_load = 1'b1;
                    end else begin
                        state_d = RD_WAIT;
                    end
                end else if (bus.awvalid) begin
                    state_d = WR_DATA;
                end
            end
            RD_WAIT: begin
                if (wait_q == DW'(1)) begin
                    state_d = RD_DATA;
                    rd_load = 1'b1;
                end
            end
            RD_DATA: begin
                rvalid_c = 1'b1;
                if (bus.rready) begin
                    if (cnt_last) begin
                        state_d = IDLE;
                    end else begin
                        rd_load   = 1'b1;
                        look_addr = addr_nxt;
                    end
                end
            end
            WR_DATA: begin
                wready_c = 1'b1;
                if (bus.wvalid && cnt_last) state_d = WR_RESP;
            end
            WR_RESP: begin
                bvalid_c = 1'b1;
                if (bus.bready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            addr_q  <= '0;
            len_q   <= '0;
            size_q  <= '0;
            burst_q <= '0;
            id_q    <= '0;
            cnt_q   <= '0;
            wait_q  <= '0;
            rdata_q <= '0;
            rresp_q <= '0;
            bresp_q <= '0;
        end else begin
            if (ar_hs) begin
                addr_q  <= bus.araddr;
                len_q   <= bus.arlen;
                size_q  <= bus.arsize;
                burst_q <= bus.arburst;
                id_q    <= bus.arid;
                cnt_q   <= '0;
                wait_q  <= DW'(RD_DELAY);
            end else if (aw_hs) begin
                addr_q  <= bus.awaddr;
                len_q   <= bus.awlen;
                size_q  <= bus.awsize;
                burst_q <= bus.awburst;
                id_q    <= bus.awid;
                cnt_q   <= '0;
                bresp_q <= RESP_OKAY;
            end
            if (state_q == RD_WAIT) wait_q <= wait_q - DW'(1);
            if (r_hs || w_hs) begin
                addr_q <= addr_nxt;
                cnt_q  <= cnt_q + 8'd1;
            end
            if (w_hs && (wr_resp > bresp_q)) bresp_q <= wr_resp;
            if (rd_load) begin
                rdata_q <= look_data;
                rresp_q <= look_resp;
            end
        end
    end

    // Memory contents survive reset.
    always_ff @(posedge clock) begin
        if (w_hs && wr_ok) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.wstrb[i]) mem[wr_idx][8*i +: 8] <= bus.wdata[8*i +: 8];
            end
        end
    end

    assign bus.arready = reset & arready_c;
    assign bus.awready = reset & awready_c;
    assign bus.wready  = reset & wready_c;
    assign bus.rvalid  = reset & rvalid_c;
    assign bus.bvalid  = reset & bvalid_c;
    assign bus.rlast   = reset & rvalid_c & cnt_last;
    assign bus.rdata   = reset ? rdata_q : 32'd0;
    assign bus.rresp   = reset ? rresp_q : 2'b00;
    assign bus.bresp   = reset ? bresp_q : 2'b00;
    assign bus.rid     = reset ? id_q : 4'd0;
    assign bus.bid     = reset ? id_q : 4'd0;
endmodule

// File: tb/tb_ysyx_25040111_axi_slave_mem.sv
// Directed bench for the AXI4 memory responder: single-beat vector table plus
// burst, arbitration, error and mid-burst reset sequences.
module tb_ysyx_25040111_axi_slave_mem;
    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    ysyx_25040111_axi_slave_mem_if axi ();

    ysyx_25040111_axi_slave_mem #(
        .MEM_AW  (10),
        .BASE    (32'h8000_0000),
        .RD_DELAY(0)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (axi)
    );

    typedef struct {
        bit          is_wr;
        logic [31:0] addr;
        logic [1:0]  burst;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  exp_resp;
        logic [31:0] exp_data;
    } vec_t;

    int          n_pass  = 0;
    int          n_total = 0;
    logic [31:0] exp_rd [256];
    logic [1:0]  exp_rr [256];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic timeout(input string name);
        n_total++;
        $display("FAIL %s: timed out", name);
    endtask

    // Entered and left at 1 time unit after a rising edge.
    task automatic axi_write(input string name, input logic [31:0] addr, input logic [3:0] id,
                             input logic [7:0] len, input logic [1:0] burst, input logic [31:0] data0,
                             input logic [3:0] strb, input int bad_beat,
                             output logic [1:0] resp, output logic [3:0] bid_o, output int beats);
        int t;
        beats = 0;
        resp  = 2'bxx;
        bid_o = 4'hx;
        axi.awvalid = 1'b1; axi.awaddr = addr; axi.awid = id; axi.awlen = len;
        axi.awsize = 3'd2; axi.awburst = burst;
        t = 0;
        #3;
        while (!axi.awready && t < 50) begin @(posedge clock); #4; t++; end
        if (t == 50) begin timeout({name, " aw"}); axi.awvalid = 1'b0; #2; return; end
        @(posedge clock); #1;
        axi.awvalid = 1'b0;
        for (int k = 0; k <= int'(len); k++) begin
            axi.wvalid = 1'b1;
            axi.wdata  = data0 + 32'(k);
            axi.wstrb  = strb;
            axi.wlast  = (k == int'(len)) ^ (k == bad_beat);
            t = 0;
            #3;
            while (!axi.wready && t < 50) begin @(posedge clock); #4; t++; end
            if (t == 50) begin timeout({name, " w"}); break; end
            beats++;
            @(posedge clock); #1;
        end
        axi.wvalid = 1'b0;
        axi.wlast  = 1'b0;
        axi.bready = 1'b1;
        t = 0;
        #3;
        while (!axi.bvalid && t < 50) begin @(posedge clock); #4; t++; end
        if (t == 50) timeout({name, " b"});
        else begin resp = axi.bresp; bid_o = axi.bid; end
        @(posedge clock); #1;
        axi.bready = 1'b0;
    endtask

    // Checks every cycle rvalid is up against exp_rd/exp_rr, including stall cycles.
    task automatic axi_read(input string name, input logic [31:0] addr, input logic [3:0] id,
                            input logic [7:0] len, input logic [1:0] burst, input bit toggle);
        int t, beats, cyc;
        axi.arvalid = 1'b1; axi.araddr = addr; axi.arid = id; axi.arlen = len;
        axi.arsize = 3'd2; axi.arburst = burst;
        t = 0;
        #3;
        while (!axi.arready && t < 50) begin @(posedge clock); #4; t++; end
        if (t == 50) begin timeout({name, " ar"}); axi.arvalid = 1'b0; #2; return; end
        @(posedge clock); #1;
        axi.arvalid = 1'b0;
        beats = 0;
        cyc   = 0;
        while (beats <= int'(len) && cyc < 2000) begin
            axi.rready = !toggle || (cyc % 2 == 0);
            #3;
            if (axi.rvalid) begin
                check($sformatf("%s[%0d] rdata", name, beats), axi.rdata, exp_rd[beats]);
                check($sformatf("%s[%0d] rresp", name, beats), 32'(axi.rresp), 32'(exp_rr[beats]));
                check($sformatf("%s[%0d] rlast", name, beats), 32'(axi.rlast), 32'(beats == int'(len)));
                check($sformatf("%s[%0d] rid", name, beats), 32'(axi.rid), 32'(id));
                if (axi.rready) beats++;
            end
            @(posedge clock); #1;
            cyc++;
        end
        axi.rready = 1'b0;
        if (beats != int'(len) + 1) timeout({name, " r beats"});
        #3;
        check({name, " rvalid after last"}, 32'(axi.rvalid), 32'd0);
        @(posedge clock); #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       vecs [15];
        logic [1:0] resp;
        logic [3:0] bid_v;
        int         beats;

        axi.awvalid = 0; axi.awaddr = 0; axi.awid = 0; axi.awlen = 0; axi.awsize = 0; axi.awburst = 0;
        axi.wvalid = 0; axi.wdata = 0; axi.wstrb = 0; axi.wlast = 0; axi.bready = 0;
        axi.arvalid = 0; axi.araddr = 0; axi.arid = 0; axi.arlen = 0; axi.arsize = 0; axi.arburst = 0;
        axi.rready = 0;

        vecs[0]  = '{1'b1, 32'h8000_0010, 2'b01, 32'hDEAD_BEEF, 4'hF, 2'b00, 32'h0};
        vecs[1]  = '{1'b0, 32'h8000_0010, 2'b01, 32'h0,         4'h0, 2'b00, 32'hDEAD_BEEF};
        vecs[2]  = '{1'b1, 32'h8000_0020, 2'b01, 32'hFFFF_FFFF, 4'hF, 2'b00, 32'h0};
        vecs[3]  = '{1'b1, 32'h8000_0020, 2'b01, 32'h1122_3344, 4'h5, 2'b00, 32'h0};
        vecs[4]  = '{1'b0, 32'h8000_0020, 2'b01, 32'h0,         4'h0, 2'b00, 32'hFF22_FF44};
        vecs[5]  = '{1'b0, 32'h7FFF_FFFC, 2'b01, 32'h0,         4'h0, 2'b11, 32'h0};
        vecs[6]  = '{1'b1, 32'h8000_0FFC, 2'b01, 32'hA5A5_5A5A, 4'hF, 2'b00, 32'h0};
        vecs[7]  = '{1'b0, 32'h8000_0FFC, 2'b01, 32'h0,         4'h0, 2'b00, 32'hA5A5_5A5A};
        vecs[8]  = '{1'b1, 32'h8000_1000, 2'b01, 32'h1234_5678, 4'hF, 2'b11, 32'h0};
        vecs[9]  = '{1'b0, 32'h8000_1000, 2'b01, 32'h0,         4'h0, 2'b11, 32'h0};
        vecs[10] = '{1'b0, 32'h8000_0012, 2'b01, 32'h0,         4'h0, 2'b00, 32'hDEAD_BEEF};
        vecs[11] = '{1'b0, 32'h8000_0010, 2'b00, 32'h0,         4'h0, 2'b00, 32'hDEAD_BEEF};
        vecs[12] = '{1'b0, 32'h8000_0010, 2'b10, 32'h0,         4'h0, 2'b10, 32'h0};
        vecs[13] = '{1'b1, 32'h8000_0010, 2'b10, 32'h0,         4'hF, 2'b10, 32'h0};
        vecs[14] = '{1'b0, 32'h8000_0010, 2'b01, 32'h0,         4'h0, 2'b00, 32'hDEAD_BEEF};

        // Reset held for two edges: every output low.
        repeat (2) @(posedge clock);
        #4;
        check("reset ctrl outputs",
              32'({axi.awready, axi.wready, axi.bvalid, axi.bresp, axi.bid, axi.arready,
                   axi.rvalid, axi.rresp, axi.rlast, axi.rid}), 32'd0);
        check("reset rdata", axi.rdata, 32'd0);
        @(posedge clock); #1;
        reset = 1'b1;
        #3;
        check("post-reset arready", 32'(axi.arready), 32'd1);
        check("post-reset awready", 32'(axi.awready), 32'd1);
        @(posedge clock); #1;

        for (int i = 0; i < 15; i++) begin
            if (vecs[i].is_wr) begin
                axi_write($sformatf("vec%0d", i), vecs[i].addr, 4'(i), 8'd0, vecs[i].burst,
                          vecs[i].data, vecs[i].strb, -1, resp, bid_v, beats);
                check($sformatf("vec%0d bresp", i), 32'(resp), 32'(vecs[i].exp_resp));
                check($sformatf("vec%0d bid", i), 32'(bid_v), 32'(i[3:0]));
            end else begin
                exp_rd[0] = vecs[i].exp_data;
                exp_rr[0] = vecs[i].exp_resp;
                axi_read($sformatf("vec%0d", i), vecs[i].addr, 4'(i), 8'd0, vecs[i].burst, 1'b0);
            end
        end

        // 8-beat INCR write, then read back with rready toggling.
        axi_write("burst wr", 32'h8000_0000, 4'h1, 8'd7, 2'b01, 32'h1000_0000, 4'hF, -1, resp, bid_v, beats);
        check("burst wr beats", 32'(beats), 32'd8);
        check("burst wr bresp", 32'(resp), 32'd0);
        for (int k = 0; k < 8; k++) begin exp_rd[k] = 32'h1000_0000 + 32'(k); exp_rr[k] = 2'b00; end
        axi_read("incr rd", 32'h8000_0000, 4'h2, 8'd7, 2'b01, 1'b1);

        // Simultaneous AR and AW: read wins, write waits until after the last R beat.
        axi.arvalid = 1; axi.araddr = 32'h8000_0010; axi.arid = 4'h3; axi.arlen = 8'd1;
        axi.arsize = 3'd2; axi.arburst = 2'b01;
        axi.awvalid = 1; axi.awaddr = 32'h8000_0040; axi.awid = 4'h5; axi.awlen = 8'd0;
        axi.awsize = 3'd2; axi.awburst = 2'b01;
        #3;
        check("arb arready", 32'(axi.arready), 32'd1);
        check("arb awready idle", 32'(axi.awready), 32'd0);
        @(posedge clock); #1;
        axi.arvalid = 0; axi.rready = 1;
        #3;
        check("arb beat0 rdata", axi.rdata, 32'h1000_0004);
        check("arb beat0 awready", 32'(axi.awready), 32'd0);
        @(posedge clock); #4;
        check("arb beat1 rdata", axi.rdata, 32'h1000_0005);
        check("arb beat1 rlast", 32'(axi.rlast), 32'd1);
        check("arb beat1 awready", 32'(axi.awready), 32'd0);
        @(posedge clock); #4;
        check("arb after rvalid", 32'(axi.rvalid), 32'd0);
        check("arb after awready", 32'(axi.awready), 32'd1);
        @(posedge clock); #1;
        axi.awvalid = 0; axi.rready = 0;
        axi.wvalid = 1; axi.wdata = 32'hCAFE_F00D; axi.wstrb = 4'hF; axi.wlast = 1;
        #3;
        check("arb wready", 32'(axi.wready), 32'd1);
        @(posedge clock); #1;
        axi.wvalid = 0; axi.wlast = 0; axi.bready = 1;
        #3;
        check("arb bvalid", 32'(axi.bvalid), 32'd1);
        check("arb bresp", 32'(axi.bresp), 32'd0);
        check("arb bid", 32'(axi.bid), 32'h5);
        @(posedge clock); #1;
        axi.bready = 0;

        // Error responses.
        axi_write("wrap wr", 32'h8000_0000, 4'h7, 8'd1, 2'b10, 32'hBAD0_0000, 4'hF, -1, resp, bid_v, beats);
        check("wrap wr beats", 32'(beats), 32'd2);
        check("wrap wr bresp", 32'(resp), 32'h2);
        axi_write("early wlast", 32'h8000_0080, 4'h8, 8'd3, 2'b01, 32'h2000_0000, 4'hF, 0, resp, bid_v, beats);
        check("early wlast beats", 32'(beats), 32'd4);
        check("early wlast bresp", 32'(resp), 32'h2);
        axi_write("cross wr", 32'h8000_0FFC, 4'h9, 8'd1, 2'b01, 32'h7777_0000, 4'hF, -1, resp, bid_v, beats);
        check("cross wr bresp", 32'(resp), 32'h3);
        check("cross wr bid", 32'(bid_v), 32'h9);
        exp_rd[0] = 32'h7777_0000; exp_rr[0] = 2'b00;
        exp_rd[1] = 32'h0;         exp_rr[1] = 2'b11;
        axi_read("cross rd", 32'h8000_0FFC, 4'hA, 8'd1, 2'b01, 1'b0);

        // Reset during beat 3 of an 8-beat read.
        axi.arvalid = 1; axi.araddr = 32'h8000_0000; axi.arid = 4'h6; axi.arlen = 8'd7;
        axi.arsize = 3'd2; axi.arburst = 2'b01;
        #3;
        check("mid-reset arready", 32'(axi.arready), 32'd1);
        @(posedge clock); #1;
        axi.arvalid = 0; axi.rready = 1;
        for (int k = 0; k < 3; k++) begin
            #3;
            check($sformatf("mid-reset beat%0d", k), axi.rdata, 32'h1000_0000 + 32'(k));
            @(posedge clock); #1;
        end
        #3;
        check("mid-reset beat3 rvalid", 32'(axi.rvalid), 32'd1);
        reset = 1'b0;
        #1;
        check("in reset rvalid", 32'(axi.rvalid), 32'd0);
        @(posedge clock); #1;
        reset = 1'b1;
        #3;
        check("after reset rvalid", 32'(axi.rvalid), 32'd0);
        check("after reset arready", 32'(axi.arready), 32'd1);
        check("after reset awready", 32'(axi.awready), 32'd1);
        repeat (3) @(posedge clock);
        #4;
        check("no late R", 32'(axi.rvalid), 32'd0);
        @(posedge clock); #1;
        axi.rready = 0;

        // Completed writes survive; the WRAP write was dropped.
        exp_rd[0] = 32'hCAFE_F00D; exp_rr[0] = 2'b00;
        axi_read("kept 0x40", 32'h8000_0040, 4'hB, 8'd0, 2'b01, 1'b0);
        exp_rd[0] = 32'h1000_0000; exp_rr[0] = 2'b00;
        axi_read("kept 0x00", 32'h8000_0000, 4'hC, 8'd0, 2'b01, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
